// File: rtl/conv_pkg.sv
// ============================================================================
// Module   : conv_pkg
// Desc     : Shared trellis constants, FSM state type and generator parity
//            helper for the rate-1/2 convolutional encoder and its decoder.
//            Macro CONV_ENC_TAIL_EN adds the TAIL state to the state type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_pkg;

    localparam int         C_SYM_W  = 2;
    localparam int         C_DEF_K  = 3;
    localparam logic [2:0] C_DEF_G0 = 3'b111;
    localparam logic [2:0] C_DEF_G1 = 3'b101;

    // Widest generator the parity helper accepts; narrower ones are zero-extended.
    localparam int         C_MAX_K  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENC  = 2'd1
`ifdef CONV_ENC_TAIL_EN
        ,
        ST_TAIL = 2'd2
`endif
    } conv_state_t;

    function automatic logic gen_parity(input logic [C_MAX_K-1:0] u,
                                        input logic [C_MAX_K-1:0] g);
        return ^(u & g);
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_encoder.sv
// ============================================================================
// Module   : conv_encoder
// Desc     : Rate-1/2 convolutional encoder, one 2-bit symbol per cycle,
//            payload MSB first. Macro CONV_ENC_TAIL_EN appends K-1 flush bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_encoder
    import conv_pkg::*;
#(
    parameter int                        SIZE_DATA_IN   = 8,
    parameter int                        SIZE_DATA_OUT  = C_SYM_W,
    parameter int                        CONSTRAINT_LEN = C_DEF_K,
    parameter logic [CONSTRAINT_LEN-1:0] G0             = C_DEF_G0,
    parameter logic [CONSTRAINT_LEN-1:0] G1             = C_DEF_G1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [SIZE_DATA_IN-1:0] i_data,
    output logic [C_SYM_W-1:0]      o_data,
    output logic                    o_valid,
    output logic                    o_ready,
    output logic                    o_done
);

    localparam int ST_W  = CONSTRAINT_LEN - 1;
    localparam int CNT_W = $clog2(SIZE_DATA_IN + CONSTRAINT_LEN);
`ifdef CONV_ENC_TAIL_EN
    localparam int FRAME_LEN = SIZE_DATA_IN + CONSTRAINT_LEN - 1;
    localparam logic [CNT_W-1:0] C_PAYLOAD_LEN = CNT_W'(SIZE_DATA_IN);
`else
    localparam int FRAME_LEN = SIZE_DATA_IN;
`endif
    localparam logic [CNT_W-1:0] C_FRAME_LEN = CNT_W'(FRAME_LEN);

    generate
        if (SIZE_DATA_OUT != C_SYM_W || CONSTRAINT_LEN < 2 || CONSTRAINT_LEN > C_MAX_K) begin : g_bad_cfg
            $error("conv_encoder: rate must be 1/2 and 2 <= CONSTRAINT_LEN <= %0d", C_MAX_K);
        end
    endgenerate

    conv_state_t             r_fsm, w_fsm_nxt;
    logic [SIZE_DATA_IN-1:0] r_shift, w_shift_nxt;
    logic [ST_W-1:0]         r_enc, w_enc_nxt, w_st;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt, w_cnt_base, w_cnt_inc;
    logic [C_SYM_W-1:0]      r_data, w_data_nxt;
    logic                    r_valid, r_done, r_ready;
    logic                    w_load, w_emit, w_last, w_b;
    logic [CONSTRAINT_LEN-1:0] w_u;

    // The registered outputs always describe the symbol emitted in the cycle
    // after the edge, so r_fsm records which kind of bit is pending next.
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_shift_nxt = r_shift;
        w_enc_nxt   = r_enc;
        w_cnt_nxt   = r_cnt;
        w_cnt_base  = r_cnt;
        w_st        = r_enc;
        w_emit      = 1'b0;
        w_b         = 1'b0;
        w_load      = r_ready & i_start;

        if (w_load) begin
            w_emit      = 1'b1;
            w_b         = i_data[SIZE_DATA_IN-1];
            w_st        = '0;
            w_cnt_base  = '0;
            w_shift_nxt = i_data << 1;
        end else begin
            case (r_fsm)
                ST_ENC: begin
                    w_emit      = 1'b1;
                    w_b         = r_shift[SIZE_DATA_IN-1];
                    w_shift_nxt = r_shift << 1;
                end
`ifdef CONV_ENC_TAIL_EN
                ST_TAIL: begin
                    w_emit = 1'b1;
                    w_b    = 1'b0;
                end
`endif
                default: ;
            endcase
        end

        w_u       = {w_b, w_st};
        w_cnt_inc = w_cnt_base + 1'b1;
        w_last    = w_emit && (w_cnt_inc == C_FRAME_LEN);

        if (w_emit) begin
            w_enc_nxt = w_u[CONSTRAINT_LEN-1:1];
            w_cnt_nxt = w_cnt_inc;
            if (w_last) begin
                w_fsm_nxt = ST_IDLE;
            end else begin
`ifdef CONV_ENC_TAIL_EN
                w_fsm_nxt = (w_cnt_inc >= C_PAYLOAD_LEN) ? ST_TAIL : ST_ENC;
`else
                w_fsm_nxt = ST_ENC;
`endif
            end
        end

        w_data_nxt = '0;
        if (w_emit) begin
            w_data_nxt = {gen_parity(C_MAX_K'(w_u), C_MAX_K'(G0)),
                          gen_parity(C_MAX_K'(w_u), C_MAX_K'(G1))};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fsm   <= ST_IDLE;
            r_shift <= '0;
            r_enc   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_shift <= w_shift_nxt;
            r_enc   <= w_enc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_emit;
            r_done  <= w_last;
            r_ready <= !w_emit || w_last;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_done  = r_done;
    assign o_ready = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_conv_encoder.sv
// ============================================================================
// Module   : tb_conv_encoder
// Desc     : Self-checking bench for conv_encoder against a convolution-sum
//            reference model; honours CONV_ENC_TAIL_EN for frame length.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_encoder;

    localparam int K = 3;
    localparam int N = 8;
`ifdef CONV_ENC_TAIL_EN
    localparam int L = N + K - 1;
`else
    localparam int L = N;
`endif

    logic       i_clk   = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic [7:0] i_data  = 8'h00;
    logic [1:0] o_data;
    logic       o_valid, o_ready, o_done;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    logic [2:0] g0 = 3'b111;
    logic [2:0] g1 = 3'b101;
    logic [1:0] const_exp [10];

    always #5 i_clk = ~i_clk;

    conv_encoder dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .i_data  (i_data),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_done  (o_done)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Symbol k is the generator-weighted XOR of input bits k, k-1, ..., k-K+1;
    // bits before the frame and past the payload are zero.
    function automatic logic [1:0] ref_sym(input logic [7:0] d, input int k);
        logic a, b, x;
        int   idx;
        a = 1'b0;
        b = 1'b0;
        for (int j = 0; j < K; j++) begin
            idx = k - j;
            x   = (idx >= 0 && idx < N) ? d[N-1-idx] : 1'b0;
            a   = a ^ (g0[K-1-j] & x);
            b   = b ^ (g1[K-1-j] & x);
        end
        return {a, b};
    endfunction

    task automatic begin_frame(input logic [7:0] d);
        i_start = 1'b1;
        i_data  = d;
    endtask

    task automatic expect_frame(input logic [7:0] d, input int n_stop, input int ign_at,
                                input bit chain, input logic [7:0] nd, input bit use_const);
        for (int k = 0; k < n_stop; k++) begin
            @(negedge i_clk);
            chk("valid", 8'(o_valid), 8'd1);
            chk("data", 8'(o_data), 8'(ref_sym(d, k)));
            if (use_const) chk("data_const", 8'(o_data), 8'(const_exp[k]));
            chk("done", 8'(o_done), 8'(k == L - 1));
            chk("ready", 8'(o_ready), 8'(k == L - 1));
            i_start = 1'b0;
            if (k == ign_at) begin
                i_start = 1'b1;
                i_data  = 8'h00;
            end
            if (chain && k == L - 1) begin
                i_start = 1'b1;
                i_data  = nd;
            end
        end
        if (n_stop == L && !chain) begin
            @(negedge i_clk);
            chk("idle_valid", 8'(o_valid), 8'd0);
            chk("idle_data", 8'(o_data), 8'd0);
            chk("idle_done", 8'(o_done), 8'd0);
            chk("idle_ready", 8'(o_ready), 8'd1);
        end
    endtask

    initial begin
        logic [7:0] d, nd;
        bit         ch;
        int         ign;

        // Reset values while held in reset, then idle after release.
        repeat (2) @(negedge i_clk);
        chk("rst_valid", 8'(o_valid), 8'd0);
        chk("rst_data", 8'(o_data), 8'd0);
        chk("rst_done", 8'(o_done), 8'd0);
        chk("rst_ready", 8'(o_ready), 8'd1);
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        chk("idle_valid0", 8'(o_valid), 8'd0);
        chk("idle_ready0", 8'(o_ready), 8'd1);

        const_exp = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
        begin_frame(8'hB0);
        expect_frame(8'hB0, L, -1, 1'b0, 8'h00, 1'b1);

        const_exp = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11};
        begin_frame(8'hFF);
        expect_frame(8'hFF, L, -1, 1'b0, 8'h00, 1'b1);

        // Gapless back-to-back frames; the second must match a standalone 8'hFF.
        begin_frame(8'hB0);
        expect_frame(8'hB0, L, -1, 1'b1, 8'hFF, 1'b0);
        expect_frame(8'hFF, L, -1, 1'b0, 8'h00, 1'b1);

        // A start pulse while busy must not disturb the frame.
        const_exp = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
        begin_frame(8'hB0);
        expect_frame(8'hB0, L, 3, 1'b0, 8'h00, 1'b1);

        // Asynchronous reset at symbol 4 discards the frame.
        begin_frame(8'hB0);
        expect_frame(8'hB0, 3, -1, 1'b0, 8'h00, 1'b1);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        chk("arst_valid", 8'(o_valid), 8'd0);
        chk("arst_data", 8'(o_data), 8'd0);
        chk("arst_done", 8'(o_done), 8'd0);
        chk("arst_ready", 8'(o_ready), 8'd1);
        repeat (2) begin
            @(negedge i_clk);
            chk("arst_hold_done", 8'(o_done), 8'd0);
            chk("arst_hold_valid", 8'(o_valid), 8'd0);
        end
        i_rst_n = 1'b1;
        repeat (3) begin
            @(negedge i_clk);
            chk("post_rst_valid", 8'(o_valid), 8'd0);
            chk("post_rst_done", 8'(o_done), 8'd0);
        end
        begin_frame(8'hB0);
        expect_frame(8'hB0, L, -1, 1'b0, 8'h00, 1'b1);

        // Random frames with random chaining, gaps and ignored starts.
        d = 8'($urandom);
        begin_frame(d);
        for (int f = 0; f < 8; f++) begin
            ch  = (f < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
            nd  = 8'($urandom);
            ign = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, L - 2)) : -1;
            expect_frame(d, L, ign, ch, nd, 1'b0);
            if (ch) begin
                d = nd;
            end else if (f < 7) begin
                repeat ($urandom_range(0, 2)) @(negedge i_clk);
                d = 8'($urandom);
                begin_frame(d);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/conv_encoder.md
# conv_encoder

Rate-1/2 convolutional encoder: the transmit-side counterpart of the Viterbi decoding path. Accepts a parallel data word on a start strobe and emits one 2-bit coded symbol per cycle with a valid strobe. The symbol stream feeds the decoder's `i_data`/`i_valid` symbol input directly, with no intermediate serializer. The default generators (7,5 octal, K=3) match the 4-state trellis the decoder implements.

## Interface
- `SIZE_DATA_IN`, default 8: payload bits per frame.
- `SIZE_DATA_OUT`, default 2: symbol width. Fixed at 2 (rate 1/2); any other value is an elaboration error.
- `CONSTRAINT_LEN`, default 3: K. Encoder state holds K-1 bits.
- `G0`, default 3'b111: generator producing `o_data[1]`. Bit [K-1] taps the current input bit.
- `G1`, default 3'b101: generator producing `o_data[0]`.

Ports (one clock; reset is asynchronous and active-low):
- `i_clk` in 1: clock.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_start` in 1: frame start strobe. Sampled only when `o_ready`=1.
- `i_data` in SIZE_DATA_IN: payload, captured on the accepted `i_start`.
- `o_data` out 2: coded symbol.
- `o_valid` out 1: `o_data` is valid this cycle.
- `o_ready` out 1: an `i_start` in this cycle is accepted.
- `o_done` out 1: one-cycle pulse with the last symbol of the frame.

## Operation
- FSM states: IDLE, ENC, TAIL. TAIL exists only with the configuration macro.
- IDLE, `i_start`=1: load `i_data` into the shift register and clear the encoder state to 0, then go to ENC. Every frame starts from state 0.
- ENC:
  - Each cycle, current bit b = MSB of the shift register; payload is sent MSB first.
  - Form u = {b, state}, where state[K-2] is the most recent bit.
  - `o_data[1]` = ^(u & G0); `o_data[0]` = ^(u & G1).
  - Shift the state in by b; shift the payload left; bit counter +1.
- After SIZE_DATA_IN symbols: go to TAIL if enabled, otherwise to IDLE.
- TAIL: K-1 cycles with b=0, flushing the state back to 0.
- Back-to-back frames:
  - `o_ready`=1 in IDLE and in the cycle that outputs the frame's last symbol.
  - An `i_start` accepted in that last-symbol cycle reloads and goes directly to ENC, giving a gapless stream.
- `i_start` while `o_ready`=0: ignored, with no effect on the current frame.
- Counter width: $clog2(SIZE_DATA_IN+K). Wraps only through reload.

## Timing
- Reset values: `o_data`=0, `o_valid`=0, `o_done`=0, `o_ready`=1. Shift register, state, counter = 0, FSM = IDLE.
- All outputs are registered.
- `i_start` accepted at edge n: first symbol valid in cycle n+1.
- Last symbol in cycle n+SIZE_DATA_IN, or n+SIZE_DATA_IN+K-1 with tail. `o_done` is high in that same cycle.
- `o_valid` is continuous for the whole frame (no bubbles).
- `o_data` = 0 whenever `o_valid`=0.
- Reset mid-frame: all outputs go to reset values immediately (asynchronous). The frame is discarded with no `o_done`, and encoding resumes only on a new `i_start` after reset release.

## Configuration
- `CONV_ENC_TAIL_EN`
  - Defined: TAIL state is compiled in; K-1 zero tail bits are appended, and a frame is SIZE_DATA_IN+K-1 symbols.
  - Undefined: no TAIL state; a frame is exactly SIZE_DATA_IN symbols and the final encoder state is not flushed.

## Structure
- Shared package `conv_pkg`:
  - FSM state enum.
  - Default CONSTRAINT_LEN, G0, G1.
  - Symbol width constant (2), shared with the decoder so both ends agree on the trellis.
- No sub-module. The generator XOR is a small function in `conv_pkg`, reusable by the decoder's branch-metric logic.

## Test plan
- Reset, then idle with no `i_start` → `o_valid`=0, `o_data`=0, `o_ready`=1, `o_done`=0.
- `i_data`=8'hB0, no tail → symbols 11,10,00,01,01,11,00,00 in cycles n+1..n+8; `o_done` only in n+8.
- `i_data`=8'hFF, `CONV_ENC_TAIL_EN` defined → 11,01,10,10,10,10,10,10,01,11; `o_done` at n+10; final state 0.
- 8'hB0 then 8'hFF, second `i_start` held in the last-symbol cycle → 16 consecutive valid symbols, two `o_done` pulses; second frame's symbols equal the standalone 8'hFF result.
- `i_start` with 8'h00 pulsed mid-frame of 8'hB0 → ignored; 8'hB0 sequence unchanged.
- `i_rst_n` low at symbol 4 of 8'hB0 → outputs clear asynchronously, no `o_done`; a new `i_start` with 8'hB0 after reset reproduces the full sequence from 11.
